timer_mmio_responder: RTL
=========================

// Module: timer_mmio_responder
// PURPOSE
//   Responder end of the CPU memory bus (MFA/MFC handshake): a memory-mapped
//   down-counting timer occupying a 16-byte window of the 9-bit address space.
//   Sits beside ram512x8 on the bus and shares address/data/size/RW with it.
//   Drives the datapath's hardwareInterrupt input when the timer expires.
// PARAMETERS
//   BASE         9'h1F0  window base; hit when address[8:4]==BASE[8:4]
//   WAIT_STATES  2       extra cycles between accepting MFA and asserting MFC (0..15)
//   PRESCALE     1       Clk cycles per COUNT decrement (>=1)
// PORTS
//   Clk                input   1   rising-edge clock
//   reset              input   1   asynchronous, active-low reset
//   memFuncActive      input   1   MFA from initiator; held until MFC seen
//   readWrite          input   1   1=read, 0=write
//   address            input   9   byte address
//   dataIn             input   32  write data, right-justified for byte/half
//   dataSize           input   2   00 byte, 01 halfword, 10 word, 11 = word
//   dataOut            output  32  read data, right-justified, zero-extended
//   memFuncComplete    output  1   MFC to initiator
//   hit                output  1   combinational window decode of address
//   hardwareInterrupt  output  1   registered STATUS.exp & CTRL.ie
// BEHAVIOUR
//   Registers (word offsets, big-endian byte lanes: offset 0 = bits 31:24):
//     0x0 CTRL   [0]en [1]autoreload [2]ie; other bits read 0
//     0x4 LOAD   32-bit reload value
//     0x8 COUNT  read-only; writes ignored
//     0xC STATUS [0]exp; write 1 to clear, write 0 no effect
//   Reset (reset=0, async): all registers 0, FSM IDLE, dataOut=0, MFC=0, irq=0.
//   FSM IDLE -> WAIT -> DONE -> IDLE:
//     IDLE: memFuncActive & hit sampled -> latch addr/rw/size/dataIn, load wait
//           counter with WAIT_STATES; go DONE directly if WAIT_STATES==0, else WAIT.
//           No hit -> stay IDLE, MFC stays 0 (other responder owns the access).
//     WAIT: counter decrements; reaching 0 -> DONE.
//     On entry to DONE: write performed / read data registered; MFC=1.
//     DONE: hold MFC and dataOut while memFuncActive=1; MFA=0 -> IDLE, MFC=0
//           the following edge. dataOut returns to 0 in IDLE.
//   Latency: MFC rises WAIT_STATES+1 edges after MFA first sampled high.
//   Abort: MFA falls in WAIT -> IDLE, no register write, MFC never asserted.
//   Sub-word: lane chosen by address[1:0] (half uses address[1]); misaligned
//     low bits ignored. Byte/half writes update only the addressed lanes.
//   Timer: prescaler counts 0..PRESCALE-1 while en=1; on wrap, COUNT decrements.
//     Tick with COUNT==0: exp<=1; autoreload ? COUNT<=LOAD : en<=0 (COUNT stays 0).
//     COUNT wraps never; en=0 freezes COUNT and clears prescaler.
//   Writing LOAD while en=0 also copies new LOAD into COUNT same edge.
//   Simultaneous events: expiry and STATUS clear on same edge -> exp stays 1;
//     CTRL write and expiry auto-clear of en on same edge -> written value wins.
//   hardwareInterrupt registered: asserts one edge after exp&ie becomes true.
// TESTING
//   1 Reset: pulse reset low mid-WAIT -> MFC=0, dataOut=0, all regs read 0.
//   2 Word write LOAD=32'd5 (WAIT_STATES=2) -> MFC high 3 edges after MFA;
//     read COUNT -> 32'd5; MFC drops one edge after MFA falls.
//   3 LOAD=3, CTRL=3'b101, PRESCALE=1 -> exp set 4 ticks after en, irq next edge,
//     en auto-cleared, COUNT=0; write STATUS=1 -> irq low next edge.
//   4 Autoreload: LOAD=2, CTRL=3'b011 -> exp every 3 ticks, COUNT cycles 2,1,0,2.
//   5 Byte write 8'hAB to 0x1F5 over LOAD=0 -> LOAD=32'h00AB0000; half read
//     at 0x1F4 -> dataOut=32'h000000AB.
//   6 Miss at 0x010 -> MFC never asserts; abort in WAIT -> no write, back to IDLE.

Source files
------------

// File: rtl/timer_mmio_responder.sv
// timer_mmio_responder: memory-mapped down-counting timer answering MFA/MFC bus accesses
module timer_mmio_responder #(
  parameter logic [8:0] BASE        = 9'h1F0,
  parameter int         WAIT_STATES = 2,
  parameter int         PRESCALE    = 1
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        memFuncActive,
  input  logic        readWrite,
  input  logic [8:0]  address,
  input  logic [31:0] dataIn,
  input  logic [1:0]  dataSize,
  output logic [31:0] dataOut,
  output logic        memFuncComplete,
  output logic        hit,
  output logic        hardwareInterrupt
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] wcnt, lat_addr, a;
  logic [1:0] lat_size, sz;
  logic [31:0] lat_data, d;
  logic lat_rw, rw;
  logic [2:0] ctrl;
  logic [31:0] load, count;
  logic exp;
  logic [PW-1:0] psc;
  logic enter_done, wr, tick, fire, w_ctrl, w_load, w_stat;
  logic [3:0] mask;
  logic [31:0] bm, wdata, cur, merged, rdata;
  logic [7:0] rbyte;
  assign hit = address[8:4] == BASE[8:4];
  assign memFuncComplete = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = memFuncActive && hit ? (WAIT_STATES == 0 ? DONE : WAIT) : IDLE;
      WAIT:    state_nx = !memFuncActive ? IDLE : wcnt == 4'd1 ? DONE : WAIT;
      DONE:    state_nx = memFuncActive ? DONE : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // Zero-wait accesses complete straight from IDLE, so use the live bus there
  assign a  = state == IDLE ? address[3:0] : lat_addr;
  assign rw = state == IDLE ? readWrite : lat_rw;
  assign sz = state == IDLE ? dataSize : lat_size;
  assign d  = state == IDLE ? dataIn : lat_data;
  assign enter_done = state != DONE && state_nx == DONE;
  assign wr = enter_done && !rw;
  assign mask = sz == 2'b00 ? 4'b1000 >> a[1:0] : sz == 2'b01 ? (a[1] ? 4'b0011 : 4'b1100) : 4'b1111;
  assign wdata = sz == 2'b00 ? {4{d[7:0]}} : sz == 2'b01 ? {2{d[15:0]}} : d;
  assign bm = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
  assign cur = a[3:2] == 2'd0 ? {29'd0, ctrl} : a[3:2] == 2'd1 ? load : a[3:2] == 2'd2 ? count : {31'd0, exp};
  assign merged = (cur & ~bm) | (wdata & bm);
  assign rbyte = cur[{~a[1:0], 3'b000} +: 8];
  assign rdata = sz == 2'b00 ? {24'd0, rbyte} : sz == 2'b01 ? {16'd0, a[1] ? cur[15:0] : cur[31:16]} : cur;
  assign w_ctrl = wr && a[3:2] == 2'd0;
  assign w_load = wr && a[3:2] == 2'd1;
  assign w_stat = wr && a[3:2] == 2'd3;
  assign tick = ctrl[0] && psc == PW'(PRESCALE - 1);
  assign fire = tick && count == '0;
  always_ff @(posedge Clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      wcnt     <= '0;
      lat_addr <= '0;
      lat_rw   <= 1'b0;
      lat_size <= '0;
      lat_data <= '0;
      dataOut  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && memFuncActive && hit) begin
        wcnt     <= 4'(WAIT_STATES);
        lat_addr <= address[3:0];
        lat_rw   <= readWrite;
        lat_size <= dataSize;
        lat_data <= dataIn;
      end else if (state == WAIT)
        wcnt <= wcnt - 4'd1;
      dataOut <= enter_done && rw ? rdata : state_nx == DONE ? dataOut : '0;
    end
  // A CTRL write outranks the one-shot en clear; expiry outranks a STATUS clear
  always_ff @(posedge Clk or negedge reset)
    if (!reset) begin
      ctrl              <= '0;
      load              <= '0;
      count             <= '0;
      exp               <= 1'b0;
      psc               <= '0;
      hardwareInterrupt <= 1'b0;
    end else begin
      psc <= tick || !ctrl[0] ? '0 : psc + 1'b1;
      if (w_ctrl)
        ctrl <= merged[2:0];
      else if (fire && !ctrl[1])
        ctrl[0] <= 1'b0;
      if (w_load)
        load <= merged;
      if (w_load && !ctrl[0])
        count <= merged;
      else if (tick)
        count <= fire ? (ctrl[1] ? load : '0) : count - 32'd1;
      exp <= fire || (exp && !(w_stat && bm[0] && wdata[0]));
      hardwareInterrupt <= exp && ctrl[2];
    end
endmodule
